// File: rtl/hash_target_checker_if.sv
// Bus bundle between the hash cores / result consumer (master) and the target checker (slave).
// Parameters must match the checker instance that this bundle is bound to.
interface hash_target_checker_if #(
  parameter int WIDTH   = 256,
  parameter int LANES   = 4,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 48
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                       target_load;
  logic [WIDTH-1:0]           target_in;
  logic [LANES-1:0]           hash_valid;
  logic [LANES*WIDTH-1:0]     hash_in;
  logic [LANES*NONCE_W-1:0]   nonce_in;
  logic                       found_valid;
  logic                       found_ack;
  logic [WIDTH-1:0]           found_hash;
  logic [NONCE_W-1:0]         found_nonce;
  logic [LANE_W-1:0]          found_lane;
  logic [CNT_W-1:0]           checked_count;
  logic [7:0]                 dropped_count;

  modport master (
    output target_load, target_in, hash_valid, hash_in, nonce_in, found_ack,
    input  found_valid, found_hash, found_nonce, found_lane, checked_count, dropped_count
  );

  modport slave (
    input  target_load, target_in, hash_valid, hash_in, nonce_in, found_ack,
    output found_valid, found_hash, found_nonce, found_lane, checked_count, dropped_count
  );
endinterface

// File: rtl/hash_target_checker.sv
// Multi-lane hash-vs-target comparator: registered compare, lowest-lane priority capture
// into a held result register with valid/ack, plus checked/dropped statistics.
module hash_target_checker #(
  parameter int WIDTH   = 256,
  parameter int LANES   = 4,
  parameter int NONCE_W = 32,
  parameter int STRICT  = 0,
  parameter int CNT_W   = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  hash_target_checker_if.slave bus
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PC_W   = $clog2(LANES + 1);

  logic [WIDTH-1:0]         r_target;
  logic [LANES-1:0]         r_hit_p1;
  logic [LANES*WIDTH-1:0]   r_hash_p1;
  logic [LANES*NONCE_W-1:0] r_nonce_p1;
  logic                     r_found_valid;
  logic [WIDTH-1:0]         r_found_hash;
  logic [NONCE_W-1:0]       r_found_nonce;
  logic [LANE_W-1:0]        r_found_lane;
  logic [CNT_W-1:0]         r_checked;
  logic [7:0]               r_dropped;

  logic [LANES-1:0]         w_hit;
  logic [LANE_W-1:0]        w_win_lane;
  logic [WIDTH-1:0]         w_win_hash;
  logic [NONCE_W-1:0]       w_win_nonce;
  logic                     w_free;
  logic                     w_capture;

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_drop(input logic [7:0] cur, input logic [PC_W-1:0] hits,
                                          input logic cap);
    int sum;
    sum = int'(cur) + int'(hits) - (cap ? 1 : 0);
    return (sum > 255) ? 8'hFF : 8'(sum);
  endfunction

  // Stage 1: full-width unsigned compare against the target held before this edge
  for (genvar g = 0; g < LANES; g++) begin : g_cmp
    logic [WIDTH-1:0] w_lane_hash;
    assign w_lane_hash = bus.hash_in[g*WIDTH +: WIDTH];
    assign w_hit[g] = bus.hash_valid[g] &&
                      ((STRICT != 0) ? (w_lane_hash < r_target) : (w_lane_hash <= r_target));
  end

  always_ff @(posedge clk) begin
    r_hash_p1  <= bus.hash_in;
    r_nonce_p1 <= bus.nonce_in;
  end

  // Stage 2: lowest-index hit wins; scan downwards so the last assignment is the lowest lane
  always_comb begin
    w_win_lane  = '0;
    w_win_hash  = '0;
    w_win_nonce = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_hit_p1[i]) begin
        w_win_lane  = LANE_W'(i);
        w_win_hash  = r_hash_p1[i*WIDTH +: WIDTH];
        w_win_nonce = r_nonce_p1[i*NONCE_W +: NONCE_W];
      end
    end
  end

  // An ack in the same cycle frees the slot, so a new winner replaces the old without a bubble
  assign w_free    = !r_found_valid || bus.found_ack;
  assign w_capture = (|r_hit_p1) && w_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target      <= '0;
      r_hit_p1      <= '0;
      r_found_valid <= 1'b0;
      r_found_hash  <= '0;
      r_found_nonce <= '0;
      r_found_lane  <= '0;
      r_checked     <= '0;
      r_dropped     <= '0;
    end else begin
      if (bus.target_load) begin
        r_target <= bus.target_in;
      end
      r_hit_p1  <= w_hit;
      r_checked <= r_checked + CNT_W'(popcount(bus.hash_valid));
      r_dropped <= sat_drop(r_dropped, popcount(r_hit_p1), w_capture);
      if (w_capture) begin
        r_found_valid <= 1'b1;
        r_found_hash  <= w_win_hash;
        r_found_nonce <= w_win_nonce;
        r_found_lane  <= w_win_lane;
      end else if (bus.found_ack) begin
        r_found_valid <= 1'b0;
      end
    end
  end

  assign bus.found_valid   = r_found_valid;
  assign bus.found_hash    = r_found_hash;
  assign bus.found_nonce   = r_found_nonce;
  assign bus.found_lane    = r_found_lane;
  assign bus.checked_count = r_checked;
  assign bus.dropped_count = r_dropped;
endmodule

// File: tb/tb_hash_target_checker.sv
// Directed bench: two checkers share stimulus, u0 non-strict with 48-bit count,
// u1 strict with a 4-bit checked counter so the wrap is reachable.
module tb_hash_target_checker;
  logic           clk;
  logic           rst;
  logic           target_load;
  logic [255:0]   target_in;
  logic [3:0]     hash_valid;
  logic [1023:0]  hash_in;
  logic [127:0]   nonce_in;
  logic           found_ack;
  int             checks;
  int             errors;

  hash_target_checker_if #(.WIDTH(256), .LANES(4), .NONCE_W(32), .CNT_W(48)) if0 ();
  hash_target_checker_if #(.WIDTH(256), .LANES(4), .NONCE_W(32), .CNT_W(4))  if1 ();

  assign if0.target_load = target_load;
  assign if0.target_in   = target_in;
  assign if0.hash_valid  = hash_valid;
  assign if0.hash_in     = hash_in;
  assign if0.nonce_in    = nonce_in;
  assign if0.found_ack   = found_ack;
  assign if1.target_load = target_load;
  assign if1.target_in   = target_in;
  assign if1.hash_valid  = hash_valid;
  assign if1.hash_in     = hash_in;
  assign if1.nonce_in    = nonce_in;
  assign if1.found_ack   = found_ack;

  hash_target_checker #(.WIDTH(256), .LANES(4), .NONCE_W(32), .STRICT(0), .CNT_W(48)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  hash_target_checker #(.WIDTH(256), .LANES(4), .NONCE_W(32), .STRICT(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [255:0] h, input logic [31:0] n);
    hash_in[i*256 +: 256] = h;
    nonce_in[i*32 +: 32]  = n;
    hash_valid[i]         = 1'b1;
  endtask

  task automatic load_target(input logic [255:0] t);
    target_in   = t;
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    hash_valid  = '0;
    found_ack   = 1'b0;
    target_load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if0.found_valid); end
    checks++; if (if0.found_hash !== 256'h0) begin errors++; $display("FAIL reset_hash: got %h want 0", if0.found_hash); end
    checks++; if (if0.found_nonce !== 32'h0) begin errors++; $display("FAIL reset_nonce: got %h want 0", if0.found_nonce); end
    checks++; if (if0.found_lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d want 0", if0.found_lane); end
    checks++; if (if0.checked_count !== 48'd0) begin errors++; $display("FAIL reset_checked: got %0d want 0", if0.checked_count); end
    checks++; if (if0.dropped_count !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", if0.dropped_count); end
  endtask

  task automatic test_single_hit();
    logic [255:0] t;
    logic [255:0] h;
    t = {32'h0, {224{1'b1}}};
    h = {64'h00000000000000AB, 192'h0};
    do_reset();
    load_target(t);
    set_lane(2, h, 32'h1234ABCD);
    tick();
    hash_valid = '0;
    checks++; if (if0.checked_count !== 48'd1) begin errors++; $display("FAIL single_checked_N1: got %0d want 1", if0.checked_count); end
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", if0.found_valid); end
    tick();
    checks++; if (if0.found_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", if0.found_valid); end
    checks++; if (if0.found_lane !== 2'd2) begin errors++; $display("FAIL single_lane: got %0d want 2", if0.found_lane); end
    checks++; if (if0.found_nonce !== 32'h1234ABCD) begin errors++; $display("FAIL single_nonce: got %h want 1234abcd", if0.found_nonce); end
    checks++; if (if0.found_hash !== h) begin errors++; $display("FAIL single_hash: got %h want %h", if0.found_hash, h); end
    checks++; if (if0.dropped_count !== 8'd0) begin errors++; $display("FAIL single_dropped: got %0d want 0", if0.dropped_count); end
    checks++; if (if0.checked_count !== 48'd1) begin errors++; $display("FAIL single_checked: got %0d want 1", if0.checked_count); end
    checks++; if (if1.found_lane !== 2'd2 || if1.found_valid !== 1'b1) begin errors++; $display("FAIL single_strict: got valid %0b lane %0d want 1/2", if1.found_valid, if1.found_lane); end
  endtask

  task automatic test_equality();
    logic [255:0] t;
    t = 256'h1000;
    do_reset();
    load_target(t);
    set_lane(0, t, 32'hE0);
    tick(); hash_valid = '0; tick();
    checks++; if (if0.found_valid !== 1'b1) begin errors++; $display("FAIL eq_nonstrict: got %0b want 1", if0.found_valid); end
    checks++; if (if1.found_valid !== 1'b0) begin errors++; $display("FAIL eq_strict: got %0b want 0", if1.found_valid); end
    checks++; if (if1.checked_count !== 4'd1) begin errors++; $display("FAIL eq_strict_checked: got %0d want 1", if1.checked_count); end
    found_ack = 1'b1; tick(); found_ack = 1'b0;
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL eq_ack_clear: got %0b want 0", if0.found_valid); end
    set_lane(0, t - 256'd1, 32'hE1);
    tick(); hash_valid = '0; tick();
    checks++; if (if0.found_valid !== 1'b1 || if0.found_nonce !== 32'hE1) begin errors++; $display("FAIL below_nonstrict: got %0b/%h want 1/e1", if0.found_valid, if0.found_nonce); end
    checks++; if (if1.found_valid !== 1'b1 || if1.found_nonce !== 32'hE1) begin errors++; $display("FAIL below_strict: got %0b/%h want 1/e1", if1.found_valid, if1.found_nonce); end
    found_ack = 1'b1; tick(); found_ack = 1'b0;
    set_lane(0, t + 256'd1, 32'hE2);
    tick(); hash_valid = '0; tick();
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL above_nonstrict: got %0b want 0", if0.found_valid); end
    checks++; if (if1.found_valid !== 1'b0) begin errors++; $display("FAIL above_strict: got %0b want 0", if1.found_valid); end
  endtask

  task automatic test_collision_and_ack();
    do_reset();
    load_target({256{1'b1}});
    set_lane(1, 256'h11, 32'h1);
    set_lane(3, 256'h33, 32'h3);
    tick();
    hash_valid = '0;
    set_lane(0, 256'h0, 32'hA0);
    tick();
    hash_valid = '0;
    checks++; if (if0.found_lane !== 2'd1 || if0.found_nonce !== 32'h1) begin errors++; $display("FAIL coll_lane: got %0d/%h want 1/1", if0.found_lane, if0.found_nonce); end
    checks++; if (if0.dropped_count !== 8'd1) begin errors++; $display("FAIL coll_dropped: got %0d want 1", if0.dropped_count); end
    tick();
    checks++; if (if0.dropped_count !== 8'd2) begin errors++; $display("FAIL held_dropped: got %0d want 2", if0.dropped_count); end
    checks++; if (if0.found_lane !== 2'd1 || if0.found_valid !== 1'b1) begin errors++; $display("FAIL held_lane: got %0d/%0b want 1/1", if0.found_lane, if0.found_valid); end
    set_lane(3, 256'h33, 32'h333);
    tick();
    hash_valid = '0;
    found_ack  = 1'b1;
    tick();
    found_ack = 1'b0;
    checks++; if (if0.found_valid !== 1'b1) begin errors++; $display("FAIL ackcoll_valid: got %0b want 1", if0.found_valid); end
    checks++; if (if0.found_lane !== 2'd3 || if0.found_nonce !== 32'h333) begin errors++; $display("FAIL ackcoll_data: got %0d/%h want 3/333", if0.found_lane, if0.found_nonce); end
    checks++; if (if0.dropped_count !== 8'd2) begin errors++; $display("FAIL ackcoll_dropped: got %0d want 2", if0.dropped_count); end
    found_ack = 1'b1; tick(); found_ack = 1'b0;
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL ack_alone: got %0b want 0", if0.found_valid); end
    checks++; if (if0.found_lane !== 2'd3 || if0.found_hash !== 256'h33) begin errors++; $display("FAIL ack_keep: got %0d/%h want 3/33", if0.found_lane, if0.found_hash); end
    checks++; if (if0.checked_count !== 48'd4) begin errors++; $display("FAIL coll_checked: got %0d want 4", if0.checked_count); end
  endtask

  task automatic test_target_race();
    do_reset();
    load_target({256{1'b1}});
    target_in   = 256'h0;
    target_load = 1'b1;
    set_lane(0, 256'h5, 32'h50);
    tick();
    target_load = 1'b0;
    set_lane(0, 256'h5, 32'h51);
    tick();
    hash_valid = '0;
    checks++; if (if0.found_valid !== 1'b1 || if0.found_nonce !== 32'h50) begin errors++; $display("FAIL race_old: got %0b/%h want 1/50", if0.found_valid, if0.found_nonce); end
    found_ack = 1'b1; tick(); found_ack = 1'b0;
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL race_new: got %0b want 0", if0.found_valid); end
    checks++; if (if0.dropped_count !== 8'd0) begin errors++; $display("FAIL race_dropped: got %0d want 0", if0.dropped_count); end
    checks++; if (if0.checked_count !== 48'd2) begin errors++; $display("FAIL race_checked: got %0d want 2", if0.checked_count); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    load_target({256{1'b1}});
    set_lane(0, 256'h7, 32'h77);
    tick();
    hash_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", if0.found_valid); end
    checks++; if (if0.checked_count !== 48'd0 || if0.dropped_count !== 8'd0) begin errors++; $display("FAIL mid_counts: got %0d/%0d want 0/0", if0.checked_count, if0.dropped_count); end
    tick();
    checks++; if (if0.found_valid !== 1'b0) begin errors++; $display("FAIL mid_late_valid: got %0b want 0", if0.found_valid); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    load_target({256{1'b1}});
    for (int i = 0; i < 4; i++) set_lane(i, 256'(i), 32'(i));
    repeat (10) tick();
    checks++; if (if0.dropped_count !== 8'd35) begin errors++; $display("FAIL drop_mid: got %0d want 35", if0.dropped_count); end
    repeat (70) tick();
    hash_valid = '0;
    tick(); tick();
    checks++; if (if0.dropped_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", if0.dropped_count); end
    checks++; if (if0.found_valid !== 1'b1 || if0.found_lane !== 2'd0) begin errors++; $display("FAIL drop_held: got %0b/%0d want 1/0", if0.found_valid, if0.found_lane); end
  endtask

  task automatic test_checked_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 256'h1, 32'h0);
    repeat (3) tick();
    hash_valid = 4'h7;
    tick();
    hash_valid = '0;
    checks++; if (if1.checked_count !== 4'd15) begin errors++; $display("FAIL wrap_allones: got %0d want 15", if1.checked_count); end
    hash_valid = 4'hF;
    tick();
    hash_valid = '0;
    checks++; if (if1.checked_count !== 4'd3) begin errors++; $display("FAIL wrap_k: got %0d want 3", if1.checked_count); end
    checks++; if (if0.checked_count !== 48'd19) begin errors++; $display("FAIL wide_checked: got %0d want 19", if0.checked_count); end
    checks++; if (if0.found_valid !== 1'b0 || if0.dropped_count !== 8'd0) begin errors++; $display("FAIL wrap_nohit: got %0b/%0d want 0/0", if0.found_valid, if0.dropped_count); end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    target_load = 1'b0;
    target_in   = '0;
    hash_valid  = '0;
    hash_in     = '0;
    nonce_in    = '0;
    found_ack   = 1'b0;
    checks      = 0;
    errors      = 0;
    test_reset();
    test_single_hit();
    test_equality();
    test_collision_and_ack();
    test_target_race();
    test_reset_midflight();
    test_drop_saturation();
    test_checked_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
